dadda_mul_arbiter: RTL and testbench
====================================

Name: dadda_mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares a single 8x8 Dadda multiplier among NREQ requesters. It selects one pending request and registers its operands. It then registers the 16-bit product and presents it on a valid/ready response channel tagged with the requester index. The block owns one instance of the existing combinational 8x8 Dadda multiplier and adds the state, pipelining and fairness around it.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester index; must satisfy 2**IDW >= NREQ

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
req  input  NREQ  per-requester request level; bit i high = requester i pending
a_in  input  8*NREQ  operand a, requester i at bits [8i+7:8i]
b_in  input  8*NREQ  operand b, same packing
ack  output  NREQ  one-hot, one-cycle pulse: operands of requester i captured
busy  output  1  high whenever state != IDLE
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_id  output  IDW  index of requester that owns rsp_z
rsp_z  output  16  unsigned product a*b

Behaviour:
- Reset values (async, on rst high): state=IDLE, ack=0, busy=0, rsp_valid=0, rsp_id=0, rsp_z=0, operand regs=0, last=NREQ-1, so requester 0 has first priority.
- States: IDLE, MUL, RESP.
- IDLE, any req bit set:
  - winner = first set bit scanning last+1, last+2, ... modulo NREQ.
  - On the clock edge: op_a/op_b <= winner's operands; id <= winner; ack <= onehot(winner); state <= MUL.
  - No req bit set: stay in IDLE, ack=0.
- MUL:
  - ack is high for exactly this cycle, then returns to 0.
  - op_a/op_b drive the Dadda multiplier.
  - On the clock edge: rsp_z <= product; rsp_id <= id; rsp_valid <= 1; state <= RESP.
- RESP:
  - rsp_valid=1; rsp_z and rsp_id stay stable until accepted.
  - rsp_ready=1: on the clock edge, rsp_valid <= 0, last <= rsp_id, state <= IDLE.
  - rsp_ready=0: hold all outputs unchanged, with no limit on stall length.
- Latency: request sampled in cycle T, ack in T+1, rsp_valid first high in T+2. With rsp_ready tied high, the next arbitration happens in T+3. Peak throughput is one product per 3 cycles.
- Requester contract:
  - Operands must be valid in the cycle req is sampled.
  - Requester deasserts req no later than the edge ending its ack cycle.
  - req is only sampled in IDLE, so a request held through RESP is not issued twice if this contract is honoured.
  - A req still high when IDLE is re-entered is treated as a new request.
- Fairness: the pointer updates only on response acceptance. Each requester waits at most NREQ-1 other transactions.
- Arithmetic: unsigned 8x8 -> 16-bit, no truncation; 0xFF*0xFF=0xFE01 must be exact.
- req changes during MUL/RESP are ignored.
- Reset mid-operation: all state returns to reset values immediately. The in-flight result is discarded with no rsp_valid, and no ack is reissued.
- busy = (state != IDLE), driven from registered state.

Test Plan:
- Single request: req=0001, a0=0x0C, b0=0x0D -> ack=0001 one cycle later; rsp_valid 2 cycles after sample with rsp_z=0x009C, rsp_id=0.
- Corner operands: requester 2, a=0xFF, b=0xFF -> rsp_z=0xFE01. Then a=0x00, b=0xA5 -> rsp_z=0x0000. Then a=0x80, b=0x02 -> 0x0100.
- Round-robin: req=1111 held, each requester dropping req after its ack, with operands a_i=i+1, b_i=0x10 -> responses in order id 0,1,2,3 with z=0x0010,0x0020,0x0030,0x0040. A second full round reissued after the first must start at id 0 (last=3).
- Back-pressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_z and rsp_id stable and busy=1. New req on requester 1 gets no ack until the cycle after rsp_ready=1 is accepted.
- Fairness after pointer move: after serving id 1, assert req=0011 -> requester 0 is not chosen first if... no: the scan starts at 2, wraps, and selects 0. Then id 1 is served next.
- Reset mid-operation: assert rst during MUL -> ack=0, rsp_valid=0, busy=0 immediately. After release with req=0100 -> ack=0100 (last reset to NREQ-1).

Source files
------------

// File: rtl/dadda_mul_arbiter_if.sv
// Request/response bundle between the requesters, the result consumer and the
// shared-multiplier arbiter.
interface dadda_mul_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] a_in;
  logic [8*NREQ-1:0] b_in;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_z;

  modport master (
    output req, a_in, b_in, rsp_ready,
    input  ack, busy, rsp_valid, rsp_id, rsp_z
  );

  modport slave (
    input  req, a_in, b_in, rsp_ready,
    output ack, busy, rsp_valid, rsp_id, rsp_z
  );
endinterface

// File: rtl/dadda_mul_arbiter.sv
// Round-robin arbiter sharing one combinational 8x8 Dadda multiplier among
// NREQ requesters, with a registered valid/ready response channel.

// Unsigned 8x8 multiplier: partial-product heights reduced 8-6-4-3-2 by full
// adders, then a final carry-propagate add.
module dadda_mul8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] z
);
  localparam int unsigned PW = 16;

  function automatic logic [PW-1:0] sum3(input logic [PW-1:0] x, y, w);
    return x ^ y ^ w;
  endfunction

  function automatic logic [PW-1:0] cry3(input logic [PW-1:0] x, y, w);
    logic [PW-1:0] m;
    m = (x & y) | (x & w) | (y & w);
    return {m[PW-2:0], 1'b0};
  endfunction

  logic [PW-1:0] pp [8];
  logic [PW-1:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = PW'({8'h00, a & {8{b[i]}}}) << i;
    end
  end

  // height 8 -> 6
  assign s0 = sum3(pp[0], pp[1], pp[2]);
  assign c0 = cry3(pp[0], pp[1], pp[2]);
  assign s1 = sum3(pp[3], pp[4], pp[5]);
  assign c1 = cry3(pp[3], pp[4], pp[5]);
  // height 6 -> 4
  assign s2 = sum3(s0, c0, s1);
  assign c2 = cry3(s0, c0, s1);
  assign s3 = sum3(c1, pp[6], pp[7]);
  assign c3 = cry3(c1, pp[6], pp[7]);
  // height 4 -> 3 -> 2
  assign s4 = sum3(s2, c2, s3);
  assign c4 = cry3(s2, c2, s3);
  assign s5 = sum3(s4, c4, c3);
  assign c5 = cry3(s4, c4, c3);

  assign z = s5 + c5;
endmodule

module dadda_mul_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input logic             clk,
  input logic             rst,
  dadda_mul_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t            state, state_d;
  logic [7:0]        op_a, op_b;
  logic [IDW-1:0]    id, last;
  logic [NREQ-1:0]   ack_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [15:0]       rsp_z_q;
  logic [15:0]       prod;

  logic              found, found_hi, found_lo;
  logic [IDW-1:0]    winner, win_hi, win_lo;
  logic [7:0]        sel_a, sel_b;
  logic              grant;

  // Round-robin pick: lowest pending index above last, else lowest overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        if (IDW'(i) > last) begin
          found_hi = 1'b1;
          win_hi   = IDW'(i);
        end else begin
          found_lo = 1'b1;
          win_lo   = IDW'(i);
        end
      end
    end
    found  = found_hi | found_lo;
    winner = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (IDW'(i) == winner) begin
        sel_a = bus.a_in[8*i +: 8];
        sel_b = bus.b_in[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state;
    grant   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant   = 1'b1;
          state_d = MUL;
        end
      end
      MUL:  state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Datapath and registered outputs; the pointer moves only on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a        <= '0;
      op_b        <= '0;
      id          <= '0;
      last        <= IDW'(NREQ - 1);
      ack_q       <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_z_q     <= '0;
    end else begin
      busy_q <= (state_d != IDLE);
      ack_q  <= grant ? (NREQ'(1) << winner) : '0;
      if (grant) begin
        op_a <= sel_a;
        op_b <= sel_b;
        id   <= winner;
      end
      if (state == MUL) begin
        rsp_z_q     <= prod;
        rsp_id_q    <= id;
        rsp_valid_q <= 1'b1;
      end
      if (state == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
        last        <= rsp_id_q;
      end
    end
  end

  dadda_mul8 u_mul (
    .a (op_a),
    .b (op_b),
    .z (prod)
  );

  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_z     = rsp_z_q;
endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Directed bench for dadda_mul_arbiter: reset, products, round-robin order,
// back-pressure, pointer movement and reset during a multiply.
module tb_dadda_mul_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  dadda_mul_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  dadda_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.a_in[8*i +: 8] = a;
    bus.b_in[8*i +: 8] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    total++; if (bus.ack !== 4'b0000) $display("FAIL reset_ack got=%b exp=0000", bus.ack); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else passed++;
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.rsp_valid); else passed++;
    total++; if (bus.rsp_id !== 2'd0) $display("FAIL reset_id got=%0d exp=0", bus.rsp_id); else passed++;
    total++; if (bus.rsp_z !== 16'h0000) $display("FAIL reset_z got=%h exp=0000", bus.rsp_z); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_ops(0, 8'h0C, 8'h0D);
    bus.req = 4'b0001;
    tick();
    total++; if (bus.ack !== 4'b0001) $display("FAIL single_ack got=%b exp=0001", bus.ack); else passed++;
    total++; if (bus.busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", bus.busy); else passed++;
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_early_valid got=%b exp=0", bus.rsp_valid); else passed++;
    bus.req = 4'b0000;
    tick();
    total++; if (bus.ack !== 4'b0000) $display("FAIL single_ack_pulse got=%b exp=0000", bus.ack); else passed++;
    total++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", bus.rsp_valid); else passed++;
    total++; if (bus.rsp_z !== 16'h009C) $display("FAIL single_z got=%h exp=009c", bus.rsp_z); else passed++;
    total++; if (bus.rsp_id !== 2'd0) $display("FAIL single_id got=%0d exp=0", bus.rsp_id); else passed++;
    tick();
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_accept got=%b exp=0", bus.rsp_valid); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL single_idle_busy got=%b exp=0", bus.busy); else passed++;
  endtask

  task automatic test_corner();
    logic [7:0]  ta [3];
    logic [7:0]  tb [3];
    logic [15:0] tz [3];
    ta = '{8'hFF, 8'h00, 8'h80};
    tb = '{8'hFF, 8'hA5, 8'h02};
    tz = '{16'hFE01, 16'h0000, 16'h0100};
    for (int k = 0; k < 3; k++) begin
      set_ops(2, ta[k], tb[k]);
      bus.req = 4'b0100;
      tick();
      total++; if (bus.ack !== 4'b0100) $display("FAIL corner%0d_ack got=%b exp=0100", k, bus.ack); else passed++;
      bus.req = 4'b0000;
      tick();
      total++; if (bus.rsp_z !== tz[k]) $display("FAIL corner%0d_z got=%h exp=%h", k, bus.rsp_z, tz[k]); else passed++;
      total++; if (bus.rsp_id !== 2'd2) $display("FAIL corner%0d_id got=%0d exp=2", k, bus.rsp_id); else passed++;
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_ops(i, 8'(i + 1), 8'h10);
    for (int r = 0; r < 2; r++) begin
      bus.req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
        tick();
        exp_ack = 4'b0001 << k;
        total++; if (bus.ack !== exp_ack) $display("FAIL rr%0d_ack%0d got=%b exp=%b", r, k, bus.ack, exp_ack); else passed++;
        bus.req[k] = 1'b0;
        tick();
        total++; if (bus.rsp_id !== 2'(k)) $display("FAIL rr%0d_id%0d got=%0d exp=%0d", r, k, bus.rsp_id, k); else passed++;
        total++; if (bus.rsp_z !== 16'((k + 1) * 16)) $display("FAIL rr%0d_z%0d got=%h exp=%h", r, k, bus.rsp_z, 16'((k + 1) * 16)); else passed++;
        tick();
      end
    end
  endtask

  task automatic test_back_pressure();
    set_ops(0, 8'h07, 8'h09);
    set_ops(1, 8'h11, 8'h03);
    bus.req = 4'b0001;
    tick();
    total++; if (bus.ack !== 4'b0001) $display("FAIL bp_ack0 got=%b exp=0001", bus.ack); else passed++;
    bus.req = 4'b0000;
    bus.rsp_ready = 1'b0;
    tick();
    bus.req = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      total++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_valid%0d got=%b exp=1", c, bus.rsp_valid); else passed++;
      total++; if (bus.rsp_z !== 16'h003F) $display("FAIL bp_z%0d got=%h exp=003f", c, bus.rsp_z); else passed++;
      total++; if (bus.rsp_id !== 2'd0) $display("FAIL bp_id%0d got=%0d exp=0", c, bus.rsp_id); else passed++;
      total++; if (bus.busy !== 1'b1) $display("FAIL bp_busy%0d got=%b exp=1", c, bus.busy); else passed++;
      total++; if (bus.ack !== 4'b0000) $display("FAIL bp_noack%0d got=%b exp=0000", c, bus.ack); else passed++;
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL bp_accept got=%b exp=0", bus.rsp_valid); else passed++;
    total++; if (bus.ack !== 4'b0000) $display("FAIL bp_ack_on_accept got=%b exp=0000", bus.ack); else passed++;
    tick();
    total++; if (bus.ack !== 4'b0010) $display("FAIL bp_ack1 got=%b exp=0010", bus.ack); else passed++;
    bus.req = 4'b0000;
    tick();
    total++; if (bus.rsp_id !== 2'd1) $display("FAIL bp_id1 got=%0d exp=1", bus.rsp_id); else passed++;
    total++; if (bus.rsp_z !== 16'h0033) $display("FAIL bp_z1 got=%h exp=0033", bus.rsp_z); else passed++;
    tick();
  endtask

  task automatic test_fairness();
    bus.req = 4'b0011;
    tick();
    total++; if (bus.ack !== 4'b0001) $display("FAIL fair_first got=%b exp=0001", bus.ack); else passed++;
    bus.req[0] = 1'b0;
    tick();
    total++; if (bus.rsp_id !== 2'd0) $display("FAIL fair_id0 got=%0d exp=0", bus.rsp_id); else passed++;
    tick();
    tick();
    total++; if (bus.ack !== 4'b0010) $display("FAIL fair_second got=%b exp=0010", bus.ack); else passed++;
    bus.req = 4'b0000;
    tick();
    total++; if (bus.rsp_id !== 2'd1) $display("FAIL fair_id1 got=%0d exp=1", bus.rsp_id); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.req = 4'b0001;
    tick();
    total++; if (bus.ack !== 4'b0001) $display("FAIL rmid_pre_ack got=%b exp=0001", bus.ack); else passed++;
    bus.req = 4'b0000;
    rst = 1'b1;
    #1;
    total++; if (bus.ack !== 4'b0000) $display("FAIL rmid_ack got=%b exp=0000", bus.ack); else passed++;
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL rmid_valid got=%b exp=0", bus.rsp_valid); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", bus.busy); else passed++;
    tick();
    rst = 1'b0;
    tick();
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL rmid_no_rsp got=%b exp=0", bus.rsp_valid); else passed++;
    total++; if (bus.ack !== 4'b0000) $display("FAIL rmid_no_reack got=%b exp=0000", bus.ack); else passed++;
    bus.req = 4'b0100;
    tick();
    total++; if (bus.ack !== 4'b0100) $display("FAIL rmid_ack2 got=%b exp=0100", bus.ack); else passed++;
    bus.req = 4'b0000;
    tick();
    total++; if (bus.rsp_z !== 16'h0030) $display("FAIL rmid_z got=%h exp=0030", bus.rsp_z); else passed++;
    total++; if (bus.rsp_id !== 2'd2) $display("FAIL rmid_id got=%0d exp=2", bus.rsp_id); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_corner();
    test_round_robin();
    test_back_pressure();
    test_fairness();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
